// File: rtl/hicore_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready command channel among NREQ requesters, with in-order response routing.
// Define HICORE_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module hicore_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int DW = 32,
  parameter int OUTS = 2,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_vld,
  output logic [NREQ-1:0]    req_rdy,
  input  logic [NREQ*DW-1:0] req_dat,
  output logic               cmd_vld,
  input  logic               cmd_rdy,
  output logic [DW-1:0]      cmd_dat,
  output logic [IDW-1:0]     cmd_id,
  input  logic               rsp_vld,
  output logic               rsp_rdy,
  input  logic [DW-1:0]      rsp_dat,
  output logic [NREQ-1:0]    rsp_vld_o,
  input  logic [NREQ-1:0]    rsp_rdy_o,
  output logic [DW-1:0]      rsp_dat_o,
  output logic               busy,
  output logic               err,
  output logic               dbg_state
);

  // Handshakes: a transfer happens on a cycle where valid and ready are both high at the rising
  // clock edge; a requester whose valid is up must hold valid and data until its ready is seen.

  localparam int PW = (OUTS > 1) ? $clog2(OUTS) : 1;
  localparam int CW = $clog2(OUTS + 1);

  typedef enum logic {ARB = 1'b0, HOLD = 1'b1} state_e;

  state_e          state;
  logic [IDW-1:0]  held;
  logic [IDW-1:0]  sel;
  logic [IDW-1:0]  gnt;
  logic [IDW-1:0]  gnt_next;
  logic            full;
  logic            empty;
  logic            accept;
  logic            pop;
  logic [IDW-1:0]  head;
  logic [IDW-1:0]  id_mem [OUTS];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

`ifndef HICORE_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]  rr_ptr;
`endif

  // Search order starts at rr_ptr (or at 0 with fixed priority); first valid requester wins.
  always_comb begin
    int j;
    logic found;
    logic [IDW-1:0] idx;
    j = 0;
    found = 1'b0;
    idx = '0;
    sel = '0;
    for (int i = 0; i < NREQ; i++) begin
`ifdef HICORE_ARB_FIXED_PRIO_EN
      j = i;
`else
      j = int'(rr_ptr) + i;
      if (j >= NREQ) j = j - NREQ;
`endif
      idx = IDW'(j);
      if (!found && req_vld[idx]) begin
        sel = idx;
        found = 1'b1;
      end
    end
  end

  assign full  = (count == CW'(OUTS));
  assign empty = (count == '0);
  assign gnt   = (state == HOLD) ? held : sel;
  assign gnt_next = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;

  // Outputs are forced idle while reset is asserted so a held request cannot leak through.
  assign cmd_vld = rst_n & ~full & ((state == HOLD) ? req_vld[held] : |req_vld);
  assign cmd_dat = req_dat[int'(gnt)*DW +: DW];
  assign cmd_id  = gnt;
  assign accept  = cmd_vld & cmd_rdy;

  always_comb begin
    req_rdy = '0;
    req_rdy[gnt] = cmd_rdy & ~full & rst_n;
  end

  assign head      = id_mem[rd_ptr];
  assign rsp_rdy   = empty ? 1'b1 : rsp_rdy_o[head];
  assign rsp_dat_o = rsp_dat;
  assign pop       = rsp_vld & rsp_rdy & ~empty;

  always_comb begin
    rsp_vld_o = '0;
    if (!empty) rsp_vld_o[head] = rsp_vld;
  end

  assign busy      = ~empty;
  assign dbg_state = (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB;
      held  <= '0;
`ifndef HICORE_ARB_FIXED_PRIO_EN
      rr_ptr <= '0;
`endif
    end else begin
      case (state)
        ARB: begin
          if (cmd_vld && !cmd_rdy) begin
            state <= HOLD;
            held  <= sel;
          end
        end
        HOLD: begin
          if (cmd_rdy) state <= ARB;
        end
        default: state <= ARB;
      endcase
`ifndef HICORE_ARB_FIXED_PRIO_EN
      if (accept) rr_ptr <= gnt_next;
`endif
    end
  end

  // Outstanding-ID FIFO; full blocks accept, so a same-cycle pop never makes room for a push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (accept) wr_ptr <= (wr_ptr == PW'(OUTS - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)    rd_ptr <= (rd_ptr == PW'(OUTS - 1)) ? '0 : rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (rsp_vld && empty) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) id_mem[wr_ptr] <= gnt;
  end

`ifdef HICORE_ARB_FIXED_PRIO_EN
  logic unused_gnt_next;
  assign unused_gnt_next = ^gnt_next;
`endif

endmodule

// File: tb/tb_hicore_rr_arbiter.sv
// Directed bench for hicore_rr_arbiter: a negedge monitor pops expected commands/responses from
// queues filled by the stimulus process; directed checks cover reset, full, stall and err cases.
module tb_hicore_rr_arbiter;
  localparam int NREQ = 2;
  localparam int DW = 32;
  localparam int OUTS = 2;
  localparam int IDW = 1;
`ifdef HICORE_ARB_FIXED_PRIO_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif
  localparam logic [DW-1:0] DAT0 = 32'hAAAA_0000;
  localparam logic [DW-1:0] DAT1 = 32'hBBBB_1111;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req_vld;
  logic [NREQ-1:0]    req_rdy;
  logic [NREQ*DW-1:0] req_dat;
  logic               cmd_vld;
  logic               cmd_rdy;
  logic [DW-1:0]      cmd_dat;
  logic [IDW-1:0]     cmd_id;
  logic               rsp_vld;
  logic               rsp_rdy;
  logic [DW-1:0]      rsp_dat;
  logic [NREQ-1:0]    rsp_vld_o;
  logic [NREQ-1:0]    rsp_rdy_o;
  logic [DW-1:0]      rsp_dat_o;
  logic               busy;
  logic               err;
  logic               dbg_state;

  int errors = 0;
  int checks = 0;
  logic [IDW+DW-1:0]  exp_cmd_q[$];
  logic [NREQ+DW-1:0] exp_rsp_q[$];

  hicore_rr_arbiter #(.NREQ(NREQ), .DW(DW), .OUTS(OUTS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_dat(req_dat),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_dat(cmd_dat), .cmd_id(cmd_id),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_dat(rsp_dat),
    .rsp_vld_o(rsp_vld_o), .rsp_rdy_o(rsp_rdy_o), .rsp_dat_o(rsp_dat_o),
    .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not reach the end, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic exp_cmd(input logic [IDW-1:0] id);
    exp_cmd_q.push_back({id, (id == 1'b1) ? DAT1 : DAT0});
  endtask

  task automatic exp_rsp(input logic [IDW-1:0] id, input logic [DW-1:0] d);
    logic [NREQ-1:0] m;
    m = '0;
    m[id] = 1'b1;
    exp_rsp_q.push_back({m, d});
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && cmd_vld && cmd_rdy) begin
      if (exp_cmd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cmd_unexpected: got id %0h data %0h required none", cmd_id, cmd_dat);
      end else begin
        chk("cmd_accept", {cmd_id, cmd_dat}, exp_cmd_q.pop_front());
      end
    end
    if (rst_n && rsp_vld && rsp_rdy && rsp_vld_o != '0) begin
      if (exp_rsp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got mask %0h data %0h required none", rsp_vld_o, rsp_dat_o);
      end else begin
        chk("rsp_route", {rsp_vld_o, rsp_dat_o}, exp_rsp_q.pop_front());
      end
    end
  end

  // Stimulus
  initial begin
    logic [IDW-1:0] id;
    logic [IDW-1:0] prev_id;
    logic [IDW-1:0] id8;
    rst_n = 1'b0;
    req_vld = 2'b11;
    req_dat = {DAT1, DAT0};
    cmd_rdy = 1'b1;
    rsp_vld = 1'b0;
    rsp_dat = '0;
    rsp_rdy_o = 2'b11;
    prev_id = '0;

    repeat (2) @(posedge clk);
    smp();
    chk("rst_cmd_vld", cmd_vld, 0);
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_rsp_vld_o", rsp_vld_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_state", dbg_state, 0);
    adv();
    rst_n = 1'b1;

    // Both requesting with slave always ready; responses drain one cycle behind.
    for (int c = 0; c < 5; c++) begin
      req_vld = (c < 4) ? 2'b11 : 2'b00;
      rsp_vld = (c >= 1);
      rsp_dat = 32'hC0DE_0000 + c;
      id = FP ? 1'b0 : IDW'(c % 2);
      if (c < 4) exp_cmd(id);
      if (c >= 1) exp_rsp(prev_id, rsp_dat);
      smp();
      if (c < 4) chk("t1_req_rdy", req_rdy, FP ? 2'b01 : ((c % 2) ? 2'b10 : 2'b01));
      prev_id = id;
      adv();
    end
    rsp_vld = 1'b0;
    smp();
    chk("t1_idle_busy", busy, 0);
    adv();

    // Grant lock while the slave stalls.
    req_vld = 2'b10;
    cmd_rdy = 1'b0;
    smp();
    chk("t2_c1_id", cmd_id, 1);
    chk("t2_c1_vld", cmd_vld, 1);
    chk("t2_c1_state", dbg_state, 0);
    adv();
    req_vld = 2'b11;
    smp();
    chk("t2_c2_id", cmd_id, 1);
    chk("t2_c2_state", dbg_state, 1);
    chk("t2_c2_req_rdy", req_rdy, 0);
    adv();
    cmd_rdy = 1'b1;
    exp_cmd(1'b1);
    smp();
    chk("t2_c3_req_rdy", req_rdy, 2'b10);
    adv();
    exp_cmd(1'b0);
    smp();
    chk("t2_c4_req_rdy", req_rdy, 2'b01);
    chk("t2_c4_state", dbg_state, 0);
    adv();

    // Two outstanding: full blocks further commands.
    smp();
    chk("t3_full_cmd_vld", cmd_vld, 0);
    chk("t3_full_req_rdy", req_rdy, 0);
    chk("t3_busy", busy, 1);
    adv();

    // Responses in order: first to requester 1 (stalled, then accepted), then requester 0.
    rsp_vld = 1'b1;
    rsp_dat = 32'h0000_00A5;
    rsp_rdy_o = 2'b01;
    smp();
    chk("t4_stall_vld_o", rsp_vld_o, 2'b10);
    chk("t4_stall_rsp_rdy", rsp_rdy, 0);
    chk("t4_rsp_dat_o", rsp_dat_o, 32'hA5);
    adv();
    rsp_rdy_o = 2'b11;
    exp_rsp(1'b1, 32'h0000_00A5);
    smp();
    chk("t4_pop_no_unblock", cmd_vld, 0);
    chk("t4_rsp_rdy", rsp_rdy, 1);
    adv();
    rsp_dat = 32'h0000_005A;
    exp_rsp(1'b0, 32'h0000_005A);
    id8 = FP ? 1'b0 : 1'b1;
    exp_cmd(id8);
    smp();
    chk("t4_push_after_pop", cmd_vld, 1);
    chk("t4_vld_o_req0", rsp_vld_o, 2'b01);
    adv();
    req_vld = 2'b00;
    rsp_dat = 32'h0000_003C;
    exp_rsp(id8, 32'h0000_003C);
    smp();
    adv();
    rsp_vld = 1'b0;
    smp();
    chk("t4_drained_busy", busy, 0);
    adv();

    // Response with nothing outstanding.
    rsp_vld = 1'b1;
    rsp_dat = 32'h0000_0077;
    smp();
    chk("t5_rsp_rdy", rsp_rdy, 1);
    chk("t5_vld_o", rsp_vld_o, 0);
    chk("t5_err_same_cycle", err, 0);
    adv();
    rsp_vld = 1'b0;
    smp();
    chk("t5_err_set", err, 1);
    repeat (3) adv();
    smp();
    chk("t5_err_sticky", err, 1);
    adv();

    // Reset in the middle of HOLD with one command outstanding.
    req_vld = 2'b01;
    cmd_rdy = 1'b1;
    exp_cmd(1'b0);
    smp();
    adv();
    req_vld = 2'b10;
    cmd_rdy = 1'b0;
    smp();
    adv();
    smp();
    chk("t6_hold_state", dbg_state, 1);
    chk("t6_hold_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_state", dbg_state, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_cmd_vld", cmd_vld, 0);
    chk("t6_rst_err", err, 0);
    adv();
    rst_n = 1'b1;
    req_vld = 2'b11;
    cmd_rdy = 1'b1;
    exp_cmd(1'b0);
    smp();
    chk("t6_rr_reset_req_rdy", req_rdy, 2'b01);
    adv();
    req_vld = 2'b00;
    cmd_rdy = 1'b0;
    rsp_vld = 1'b1;
    rsp_dat = 32'h0000_0099;
    exp_rsp(1'b0, 32'h0000_0099);
    smp();
    adv();
    rsp_vld = 1'b0;
    smp();
    chk("t6_final_busy", busy, 0);
    chk("t6_final_err", err, 0);

    chk("cmd_queue_empty", exp_cmd_q.size(), 0);
    chk("rsp_queue_empty", exp_rsp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
